// File: rtl/apb_req_arbiter.sv
// Two-client APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// PREADY wait with an optional ACCESS-phase timeout.
module apb_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             rr_last;
    logic             pick;
    logic             ready_hit;
    logic             timeout_hit;

    // rr_last is both the current grantee and the round-robin pointer; reset to 1
    // so client 0 wins the first tie.
    assign pick        = req1 && (!req0 || !rr_last);
    assign ready_hit   = (state == ACCESS) && PREADY;
    assign timeout_hit = (state == ACCESS) && !PREADY && (TIMEOUT != 0) && (wait_cnt == CNT_LIMIT);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        case (state)
            IDLE:   if (req0 || req1) next_state = SETUP;
            SETUP: begin
                PSEL       = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (ready_hit || timeout_hit) next_state = DONE;
            end
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rr_last  <= 1'b1;
            wait_cnt <= '0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            err0     <= 1'b0;
            err1     <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        rr_last <= pick;
                        PWRITE  <= pick ? wr1    : wr0;
                        PADDR   <= pick ? addr1  : addr0;
                        PWDATA  <= pick ? wdata1 : wdata0;
                    end
                end
                SETUP: wait_cnt <= '0;
                ACCESS: begin
                    if (PREADY) begin
                        if (rr_last) begin
                            done1 <= 1'b1;
                            err1  <= PSLVERR;
                            if (!PWRITE) rdata1 <= PRDATA;
                        end else begin
                            done0 <= 1'b1;
                            err0  <= PSLVERR;
                            if (!PWRITE) rdata0 <= PRDATA;
                        end
                    end else if (timeout_hit) begin
                        if (rr_last) begin
                            done1  <= 1'b1;
                            err1   <= 1'b1;
                            rdata1 <= '0;
                        end else begin
                            done0  <= 1'b1;
                            err0   <= 1'b1;
                            rdata0 <= '0;
                        end
                    end else if (wait_cnt != CNT_SAT) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
